wb_ram_slave: RTL and testbench
===============================

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: Wishbone data width in bits.
REQ-002 SHALL have parameter GRANULARITY, default 32: bits per select lane; SEL_WIDTH = DATA_WIDTH/GRANULARITY.
REQ-003 SHALL have parameter DEPTH, default 10: log2 of the number of DATA_WIDTH-bit lines stored.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of line 0, aligned to the window size.
REQ-005 SHALL have parameter WAIT_STATES, default 1: extra cycles between accept and response, range 0..15.
REQ-006 SHALL have ports, one per line:
clk  input  1  sole clock, rising edge
rst  input  1  reset, asynchronous, active-low
wb_adr_i  input  32  byte address; bits [log2(DATA_WIDTH/8)-1:0] ignored
wb_dat_i  input  DATA_WIDTH  write data
wb_dat_o  output  DATA_WIDTH  read data
wb_we_i  input  1  1 = write, 0 = read
wb_sel_i  input  SEL_WIDTH  lane enables, bit k covers bits [k*GRANULARITY +: GRANULARITY]
wb_stb_i  input  1  strobe
wb_cyc_i  input  1  cycle valid
wb_ack_o  output  1  normal termination
wb_err_o  output  1  error termination
wb_rty_o  output  1  retry termination

Function
REQ-007 SHALL implement a state machine with states IDLE, WAIT, RESP.
REQ-008 In IDLE, wb_cyc_i & wb_stb_i at a rising edge SHALL accept the request: latch address, we, sel, write data; go to WAIT with counter = WAIT_STATES, or to RESP if WAIT_STATES = 0.
REQ-009 In WAIT, the counter SHALL decrement each cycle; at 1 it SHALL transition to RESP.
REQ-010 In RESP, exactly one of wb_ack_o/wb_err_o SHALL be high for exactly one cycle, then state SHALL return to IDLE; a request accepted at edge T yields termination during the cycle after edge T+1+WAIT_STATES.
REQ-011 No request SHALL be accepted in the RESP cycle; next acceptance is earliest the first IDLE edge (throughput one transfer per WAIT_STATES+2 cycles).
REQ-012 Line index SHALL be latched address bits [log2(DATA_WIDTH/8)+DEPTH-1 : log2(DATA_WIDTH/8)].
REQ-013 An accepted write SHALL update only the lanes whose latched sel bit is 1, committed on the edge leaving RESP; sel = 0 SHALL still acknowledge with no change.
REQ-014 An accepted read SHALL drive wb_dat_o with the full stored line during the termination cycle; wb_dat_o SHALL hold its last value otherwise, and SHALL be unchanged by writes and errors.
REQ-015 If wb_cyc_i is low at any edge in WAIT or RESP, the transfer SHALL abort: return to IDLE, no termination, no write performed.
REQ-016 Inputs changing after acceptance SHALL NOT affect the in-flight transfer.
REQ-017 wb_rty_o SHALL be constant 0.
REQ-018 A write followed by a read to the same line SHALL return the written data (no read-before-write hazard).

Reset
REQ-019 While rst = 0: state IDLE, counter 0, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0; memory contents undefined.
REQ-020 rst asserted mid-transfer SHALL cancel it with no termination and no write; the first accept is possible on the first edge after release.

Configuration
REQ-021 Macro WB_RAM_SLAVE_RANGE_ERR_EN defined: a request whose address lies outside [BASE_ADDR, BASE_ADDR + 2^DEPTH*DATA_WIDTH/8) SHALL terminate with wb_err_o (same latency as REQ-010), no write, wb_dat_o unchanged.
REQ-022 Macro undefined: the address SHALL NOT be range-checked; upper bits alias via REQ-012, every transfer terminates with wb_ack_o, and wb_err_o SHALL be constant 0.

Verification
REQ-023 WAIT_STATES=1: write adr 0x10, dat 0x0123...CDEF (128-bit), sel 4'hF, accept edge 0 -> ack high exactly in the cycle after edge 2, err low.
REQ-024 Read adr 0x10 after REQ-023 -> ack after 2 wait cycles, wb_dat_o = written value; then write sel 4'b0010 with dat all ones, read back -> only bits [63:32] all ones.
REQ-025 WAIT_STATES=3: hold cyc/stb high continuously -> acks spaced 5 cycles apart, never two consecutive ack cycles.
REQ-026 Drop wb_cyc_i during WAIT of a write to 0x20 -> no ack, no err; subsequent read of 0x20 returns prior contents.
REQ-027 Macro defined, DEPTH=10: read adr 0x0000_4000 -> err pulse, ack low, wb_dat_o unchanged; macro undefined: same read -> ack with line 0 data.
REQ-028 Assert rst low during WAIT of a write -> ack/err stay 0, wb_dat_o = 0, line unchanged after release.

Source files
------------

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave backed by a line-wide RAM with a fixed response latency.
// Optional address range error termination: define WB_RAM_SLAVE_RANGE_ERR_EN.
//
// state | meaning
// IDLE  | waiting for cyc & stb; request latched on accept
// WAIT  | counting down WAIT_STATES before the response edge
// RESP  | response edge: commit write / fetch read, raise ack or err next cycle
module wb_ram_slave #(
    parameter int          DATA_WIDTH  = 128,
    parameter int          GRANULARITY = 32,
    parameter int          DEPTH       = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    localparam int         SEL_WIDTH   = DATA_WIDTH / GRANULARITY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic                  wb_we_i,
    input  logic [SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o
);

    localparam int         OFF       = $clog2(DATA_WIDTH / 8);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept;
    logic                    commit;
    logic                    range_err;

    logic [DEPTH-1:0]        idx_q;
    logic                    we_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic                    bad_q;
    logic                    ack_q;
    logic [DATA_WIDTH-1:0]   rdat_q;

    logic [DATA_WIDTH-1:0]   mem [2**DEPTH];

    // Only the line index bits matter; the rest is read here so nothing dangles.
    logic                    unused_adr;
    assign unused_adr = ^wb_adr_i;

`ifdef WB_RAM_SLAVE_RANGE_ERR_EN
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd1 << (OFF + DEPTH));

    assign range_err = ({1'b0, wb_adr_i} < WIN_LO) || ({1'b0, wb_adr_i} >= WIN_HI);
`else
    assign range_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    accept  = 1'b1;
                    state_d = NO_WAIT ? RESP : WAIT;
                    cnt_d   = NO_WAIT ? 4'd0 : WAIT_INIT;
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                // An abandoned cycle leaves without terminating or writing.
                commit  = wb_cyc_i;
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
            bad_q <= 1'b0;
        end else if (accept) begin
            idx_q <= wb_adr_i[OFF+DEPTH-1:OFF];
            we_q  <= wb_we_i;
            sel_q <= wb_sel_i;
            dat_q <= wb_dat_i;
            bad_q <= range_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            ack_q <= commit && !bad_q;
            if (commit && !we_q && !bad_q) begin
                rdat_q <= mem[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && we_q && !bad_q) begin
            for (int k = 0; k < SEL_WIDTH; k++) begin
                if (sel_q[k]) begin
                    mem[idx_q][k*GRANULARITY +: GRANULARITY] <= dat_q[k*GRANULARITY +: GRANULARITY];
                end
            end
        end
    end

`ifdef WB_RAM_SLAVE_RANGE_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= commit && bad_q;
        end
    end

    assign wb_err_o = err_q;
`else
    assign wb_err_o = 1'b0;
`endif

    assign wb_ack_o = ack_q;
    assign wb_dat_o = rdat_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: latency, lane writes, abort, reset, range handling, throughput.
module tb_wb_ram_slave;

    logic         clk;
    logic         rst;
    logic [31:0]  adr;
    logic [127:0] dat_i;
    logic [127:0] dat_o;
    logic         we;
    logic [3:0]   sel;
    logic         stb;
    logic         cyc;
    logic         ack;
    logic         err;
    logic         rty;

    logic [31:0]  adr3;
    logic [127:0] dat3_i;
    logic [127:0] dat3_o;
    logic         we3;
    logic [3:0]   sel3;
    logic         stb3;
    logic         cyc3;
    logic         ack3;
    logic         err3;
    logic         rty3;

    int checks;
    int errors;

    wb_ram_slave #(.WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty)
    );

    wb_ram_slave #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .wb_adr_i(adr3), .wb_dat_i(dat3_i), .wb_dat_o(dat3_o),
        .wb_we_i(we3), .wb_sel_i(sel3), .wb_stb_i(stb3), .wb_cyc_i(cyc3),
        .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer on the WAIT_STATES=1 instance; inputs may be scrambled right after accept.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [127:0] d,
                        input logic [3:0] s, input bit scramble,
                        output int lat, output logic got_ack, output logic got_err,
                        output logic [127:0] dout, output logic extra);
        we = w; adr = a; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        if (scramble) begin
            we = ~w; adr = ~a; dat_i = ~d; sel = ~s;
        end
        lat = 0; got_ack = 1'b0; got_err = 1'b0; dout = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                lat = k; got_ack = ack; got_err = err; dout = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        extra = ack || err;
    endtask

    localparam logic [127:0] D1   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D1M  = 128'h0123456789ABCDEF_FFFFFFFF_89ABCDEF;
    localparam logic [127:0] D2   = 128'hCAFEBABE_DEADBEEF_11223344_55667788;
    localparam logic [127:0] D3   = 128'h0F0F0F0F_F0F0F0F0_A5A5A5A5_5A5A5A5A;
    localparam logic [127:0] D4   = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] D5   = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
    localparam logic [127:0] ONES = '1;

    initial begin
        int           lat;
        logic         a;
        logic         e;
        logic         x;
        logic [127:0] q;
        logic         seen;
        int           n_ack;
        int           first_k;
        int           last_k;
        logic         bad_gap;

        checks = 0; errors = 0;
        rst = 1'b0;
        adr = '0; dat_i = '0; we = 1'b0; sel = '0; stb = 1'b0; cyc = 1'b0;
        adr3 = '0; dat3_i = '0; we3 = 1'b0; sel3 = 4'hF; stb3 = 1'b0; cyc3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", ack, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_dat", dat_o, '0);
        chk("reset_rty", rty, 1'b0);
        rst = 1'b1;

        xfer(1'b1, 32'h10, D1, 4'hF, 1'b0, lat, a, e, q, x);
        chk("wr_lat", lat, 2);
        chk("wr_ack", a, 1'b1);
        chk("wr_err", e, 1'b0);
        chk("wr_dat_o_held", q, '0);
        chk("wr_single_pulse", x, 1'b0);

        xfer(1'b0, 32'h10, '0, 4'hF, 1'b0, lat, a, e, q, x);
        chk("rd_lat", lat, 2);
        chk("rd_ack", a, 1'b1);
        chk("rd_data", q, D1);

        xfer(1'b1, 32'h10, ONES, 4'b0010, 1'b0, lat, a, e, q, x);
        chk("lane_wr_ack", a, 1'b1);
        chk("lane_wr_dat_o_held", q, D1);
        xfer(1'b0, 32'h10, '0, 4'hF, 1'b0, lat, a, e, q, x);
        chk("lane_rd_data", q, D1M);

        xfer(1'b1, 32'h10, ONES, 4'b0000, 1'b0, lat, a, e, q, x);
        chk("sel0_ack", a, 1'b1);
        xfer(1'b0, 32'h10, '0, 4'hF, 1'b0, lat, a, e, q, x);
        chk("sel0_unchanged", q, D1M);

        xfer(1'b1, 32'h30, D2, 4'hF, 1'b1, lat, a, e, q, x);
        chk("scr_wr_ack", a, 1'b1);
        xfer(1'b0, 32'h30, '0, 4'hF, 1'b1, lat, a, e, q, x);
        chk("scr_rd_data", q, D2);
        xfer(1'b0, 32'h30, '0, 4'hF, 1'b0, lat, a, e, q, x);
        chk("scr_rd_no_write", q, D2);

        xfer(1'b1, 32'h20, D3, 4'hF, 1'b0, lat, a, e, q, x);
        we = 1'b1; adr = 32'h20; dat_i = ONES; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack || err) seen = 1'b1;
        end
        chk("abort_no_term", seen, 1'b0);
        xfer(1'b0, 32'h20, '0, 4'hF, 1'b0, lat, a, e, q, x);
        chk("abort_no_write", q, D3);

        xfer(1'b1, 32'h0, D4, 4'hF, 1'b0, lat, a, e, q, x);
        xfer(1'b0, 32'h4000, '0, 4'hF, 1'b0, lat, a, e, q, x);
        chk("range_lat", lat, 2);
`ifdef WB_RAM_SLAVE_RANGE_ERR_EN
        chk("range_err", e, 1'b1);
        chk("range_ack", a, 1'b0);
        chk("range_dat_held", q, D3);
`else
        chk("alias_err", e, 1'b0);
        chk("alias_ack", a, 1'b1);
        chk("alias_data", q, D4);
`endif

        xfer(1'b1, 32'h40, D5, 4'hF, 1'b0, lat, a, e, q, x);
        we = 1'b1; adr = 32'h40; dat_i = ONES; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_dat", dat_o, '0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack || err || (dat_o !== '0)) seen = 1'b1;
        end
        chk("rst_mid_quiet", seen, 1'b0);
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b1;
        xfer(1'b0, 32'h40, '0, 4'hF, 1'b0, lat, a, e, q, x);
        chk("rst_after_lat", lat, 2);
        chk("rst_line_kept", q, D5);

        cyc3 = 1'b1; stb3 = 1'b1;
        n_ack = 0; first_k = 0; last_k = 0; bad_gap = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (ack3) begin
                n_ack++;
                if (first_k == 0) first_k = k;
                if (last_k != 0 && (k - last_k) != 5) bad_gap = 1'b1;
                last_k = k;
            end
        end
        cyc3 = 1'b0; stb3 = 1'b0;
        chk("tput_count", n_ack, 6);
        chk("tput_first", first_k, 5);
        chk("tput_spacing", bad_gap, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
